// File: rtl/fp_mul_pkg.sv
// Shared constants and FSM encoding for the parametrised floating-point multiplier.
package fp_mul_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MULT,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

endpackage

// File: rtl/fp_sig_mul_seq.sv
// Iterative shift-add NxN unsigned multiplier, one multiplier bit per cycle.
module fp_sig_mul_seq #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] prod,
  output logic           done
);

  localparam int CW = $clog2(N + 1);

  logic [N-1:0]   mcand_reg;
  logic [2*N-1:0] acc_reg;
  logic [CW-1:0]  cnt_reg;
  logic           run_reg;
  logic [N:0]     sum;
  logic [2*N-1:0] acc_next;

  // Upper half accumulates; the multiplier shifts out of the lower half.
  assign sum      = {1'b0, acc_reg[2*N-1:N]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_next = {sum, acc_reg[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (start) begin
      mcand_reg <= a;
      acc_reg   <= {{N{1'b0}}, b};
      cnt_reg   <= CW'(N);
      run_reg   <= 1'b1;
    end else if (run_reg) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg - CW'(1);
      if (cnt_reg == CW'(1)) run_reg <= 1'b0;
    end
  end

  // done marks the final step; prod is complete from the following cycle.
  assign done = run_reg && (cnt_reg == CW'(1));
  assign prod = acc_reg;

endmodule

// File: rtl/fp_mul_param.sv
// Multi-cycle IEEE-754 multiplier with parametrised widths, run-time rounding and flags.
module fp_mul_param
  import fp_mul_pkg::*;
#(
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ready,
  input  logic [W-1:0] op1,
  input  logic [W-1:0] op2,
  input  logic [1:0]   rnd_mode,
  output logic [W-1:0] res,
  output logic         done,
  output logic         busy,
  output logic [3:0]   flags
);

  localparam int N  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_SAT  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0]     EXP_MAXF = EXP_W'((1 << EXP_W) - 2);

  state_t                 state_reg, state_next;
  logic [W-1:0]           op_reg [2];
  logic [1:0]             rm_reg;
  logic                   sign_reg;
  logic signed [EW-1:0]   exp_reg;
  logic [N-1:0]           sig_reg;
  logic                   guard_reg, sticky_reg;
  logic [W-1:0]           res_reg;
  logic [3:0]             flags_reg;

  logic [EXP_W-1:0]       exp_fld [2];
  logic [N-1:0]           sig_fld [2];
  logic [1:0]             is_zero, is_inf, is_nan;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      // Subnormals share the zero class, which flushes them silently.
      assign exp_fld[gi] = op_reg[gi][W-2 -: EXP_W];
      assign sig_fld[gi] = {1'b1, op_reg[gi][MAN_W-1:0]};
      assign is_zero[gi] = (exp_fld[gi] == '0);
      assign is_inf[gi]  = (&exp_fld[gi]) && (op_reg[gi][MAN_W-1:0] == '0);
      assign is_nan[gi]  = (&exp_fld[gi]) && (op_reg[gi][MAN_W-1:0] != '0);
    end
  endgenerate

  logic                 sign_u, special;
  logic signed [EW-1:0] exp_u;
  logic [W-1:0]         spec_res;
  logic [3:0]           spec_flags;

  assign sign_u  = op_reg[0][W-1] ^ op_reg[1][W-1];
  assign exp_u   = $signed({2'b00, exp_fld[0]}) + $signed({2'b00, exp_fld[1]}) - EXP_BIAS;
  assign special = |{is_zero, is_inf, is_nan};

  always_comb begin
    spec_res   = {sign_u, {(W-1){1'b0}}};
    spec_flags = '0;
    if ((|is_nan) || ((|is_inf) && (|is_zero))) begin
      spec_res              = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags[FLG_INV]   = 1'b1;
    end else if (|is_inf) begin
      spec_res = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic           mul_start, mul_done;
  logic [2*N-1:0] prod;

  assign mul_start = (state_reg == ST_UNPACK) && !special;

  fp_sig_mul_seq #(.N(N)) u_sig_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (sig_fld[0]),
    .b     (sig_fld[1]),
    .prod  (prod),
    .done  (mul_done)
  );

  logic [N-1:0]         norm_sig;
  logic                 norm_guard, norm_sticky;
  logic signed [EW-1:0] norm_exp;

  always_comb begin
    if (prod[2*N-1]) begin
      norm_sig    = prod[2*N-1 -: N];
      norm_guard  = prod[N-1];
      norm_sticky = |prod[N-2:0];
      norm_exp    = exp_reg + EXP_ONE;
    end else begin
      norm_sig    = prod[2*N-2 -: N];
      norm_guard  = prod[N-2];
      norm_sticky = |prod[N-3:0];
      norm_exp    = exp_reg;
    end
  end

  logic                 round_inc, to_inf;
  logic [N:0]           sig_inc;
  logic [MAN_W-1:0]     rnd_frac;
  logic signed [EW-1:0] rnd_exp;
  logic [W-1:0]         rnd_res;
  logic [3:0]           rnd_flags;

  always_comb begin
    case (rm_reg)
      RM_RNE:  round_inc = guard_reg & (sticky_reg | sig_reg[0]);
      RM_RUP:  round_inc = (guard_reg | sticky_reg) & ~sign_reg;
      RM_RDN:  round_inc = (guard_reg | sticky_reg) & sign_reg;
      default: round_inc = 1'b0;
    endcase
    to_inf  = (rm_reg == RM_RNE) || ((rm_reg == RM_RUP) && !sign_reg) ||
              ((rm_reg == RM_RDN) && sign_reg);
    sig_inc = {1'b0, sig_reg} + {{N{1'b0}}, round_inc};
    // A carry out leaves 10...0, so renormalising is a shift and exponent bump.
    if (sig_inc[N]) begin
      rnd_frac = sig_inc[MAN_W:1];
      rnd_exp  = exp_reg + EXP_ONE;
    end else begin
      rnd_frac = sig_inc[MAN_W-1:0];
      rnd_exp  = exp_reg;
    end
    rnd_res            = {sign_reg, rnd_exp[EXP_W-1:0], rnd_frac};
    rnd_flags          = '0;
    rnd_flags[FLG_INX] = guard_reg | sticky_reg;
    if (rnd_exp >= EXP_SAT) begin
      rnd_flags[FLG_OVF] = 1'b1;
      rnd_flags[FLG_INX] = 1'b1;
      rnd_res = to_inf ? {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                       : {sign_reg, EXP_MAXF, {MAN_W{1'b1}}};
    end else if (rnd_exp <= EXP_ZERO) begin
      rnd_flags[FLG_UNF] = 1'b1;
      rnd_flags[FLG_INX] = 1'b1;
      rnd_res            = {sign_reg, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (ready) state_next = ST_UNPACK;
      ST_UNPACK: state_next = special ? ST_DONE : ST_MULT;
      ST_MULT:   if (mul_done) state_next = ST_NORM;
      ST_NORM:   state_next = ST_ROUND;
      ST_ROUND:  state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      res_reg   <= '0;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: if (ready) begin
          op_reg[0] <= op1;
          op_reg[1] <= op2;
          rm_reg    <= rnd_mode;
        end
        ST_UNPACK: begin
          sign_reg <= sign_u;
          exp_reg  <= exp_u;
          if (special) begin
            res_reg   <= spec_res;
            flags_reg <= spec_flags;
          end
        end
        ST_NORM: begin
          sig_reg    <= norm_sig;
          guard_reg  <= norm_guard;
          sticky_reg <= norm_sticky;
          exp_reg    <= norm_exp;
        end
        ST_ROUND: begin
          res_reg   <= rnd_res;
          flags_reg <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign res   = res_reg;
  assign flags = flags_reg;
  assign done  = (state_reg == ST_DONE);
  assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fp_mul_param.sv
// Directed-vector bench for fp_mul_param in single and half precision.
module tb_fp_mul_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [1:0]  rnd_mode = 2'b00;
  logic [31:0] res;
  logic        done, busy;
  logic [3:0]  flags;

  logic        ready_h = 1'b0;
  logic [15:0] op1_h = '0, op2_h = '0;
  logic [1:0]  rnd_mode_h = 2'b00;
  logic [15:0] res_h;
  logic        done_h, busy_h;
  logic [3:0]  flags_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mul_param dut (
    .clk(clk), .rst(rst), .ready(ready), .op1(op1), .op2(op2), .rnd_mode(rnd_mode),
    .res(res), .done(done), .busy(busy), .flags(flags)
  );

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .ready(ready_h), .op1(op1_h), .op2(op2_h), .rnd_mode(rnd_mode_h),
    .res(res_h), .done(done_h), .busy(busy_h), .flags(flags_h)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycle 1 is the first cycle after the accept edge.
  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input int pulse_at,
                        output logic [31:0] r, output logic [3:0] f,
                        output int dcyc, output int dcnt,
                        output logic b1, output logic bd, output logic ba,
                        output logic [31:0] rhold);
    logic d, bz;
    r = '0; f = '0; dcyc = 0; dcnt = 0; b1 = 1'b0; bd = 1'b0; ba = 1'b1;
    if (half) begin
      ready_h = 1'b1; op1_h = a[15:0]; op2_h = b[15:0]; rnd_mode_h = rm;
    end else begin
      ready = 1'b1; op1 = a; op2 = b; rnd_mode = rm;
    end
    tick();
    ready = 1'b0; ready_h = 1'b0;
    op1 = 32'h3FA00000; op2 = 32'h3F800000; rnd_mode = ~rm;
    op1_h = 16'h3D00; op2_h = 16'h3C00; rnd_mode_h = ~rm;
    for (int c = 1; c <= 40; c++) begin
      d  = half ? done_h : done;
      bz = half ? busy_h : busy;
      if (c == 1) b1 = bz;
      if (dcnt > 0 && c == dcyc + 1) ba = bz;
      if (d) begin
        dcnt++;
        dcyc = c;
        r    = half ? {16'h0, res_h} : res;
        f    = half ? flags_h : flags;
        bd   = bz;
      end
      if (c == pulse_at) begin
        if (half) begin ready_h = 1'b1; op1_h = 16'h7C00; op2_h = 16'h0000; end
        else begin ready = 1'b1; op1 = 32'h7F800000; op2 = 32'h0; end
      end else begin
        ready = 1'b0; ready_h = 1'b0;
      end
      tick();
    end
    rhold = half ? {16'h0, res_h} : res;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (res !== 32'h0)   begin errors++; $display("FAIL reset_res got %h want 00000000", res); end
    checks++; if (flags !== 4'h0)  begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    tick();
    $display("reset: res=%h flags=%b done=%b busy=%b", res, flags, done, busy);
  endtask

  task automatic test_basic;
    logic [31:0] r, rh; logic [3:0] f; int dc, dn; logic b1, bd, ba;
    run_op(1'b0, 32'h40000000, 32'h40200000, 2'b00, 0, r, f, dc, dn, b1, bd, ba, rh);
    $display("basic 2.0*2.5: res=%h flags=%b done_cycle=%0d dones=%0d", r, f, dc, dn);
    checks++; if (r !== 32'h40A00000) begin errors++; $display("FAIL basic_res got %h want 40a00000", r); end
    checks++; if (f !== 4'b0000)      begin errors++; $display("FAIL basic_flags got %b want 0000", f); end
    checks++; if (dc !== 28)          begin errors++; $display("FAIL basic_latency got %0d want 28", dc); end
    checks++; if (dn !== 1)           begin errors++; $display("FAIL basic_done_count got %0d want 1", dn); end
    checks++; if (b1 !== 1'b1)        begin errors++; $display("FAIL basic_busy_c1 got %b want 1", b1); end
    checks++; if (bd !== 1'b1)        begin errors++; $display("FAIL basic_busy_done got %b want 1", bd); end
    checks++; if (ba !== 1'b0)        begin errors++; $display("FAIL basic_busy_after got %b want 0", ba); end
    checks++; if (rh !== 32'h40A00000) begin errors++; $display("FAIL basic_res_hold got %h want 40a00000", rh); end
  endtask

  task automatic test_special;
    logic [31:0] a, b, er, r, rh; logic [3:0] ef, f; int dc, dn; logic b1, bd, ba;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 32'h42C86666; b = 32'h80000000; er = 32'h80000000; ef = 4'b0000; end
        1:       begin a = 32'hFF800000; b = 32'h45185B75; er = 32'hFF800000; ef = 4'b0000; end
        default: begin a = 32'h7F800000; b = 32'h00000000; er = 32'h7FC00000; ef = 4'b1000; end
      endcase
      run_op(1'b0, a, b, 2'b00, 0, r, f, dc, dn, b1, bd, ba, rh);
      $display("special %h*%h: res=%h flags=%b done_cycle=%0d", a, b, r, f, dc);
      checks++; if (r !== er)  begin errors++; $display("FAIL special%0d_res got %h want %h", i, r, er); end
      checks++; if (f !== ef)  begin errors++; $display("FAIL special%0d_flags got %b want %b", i, f, ef); end
      checks++; if (dc !== 2)  begin errors++; $display("FAIL special%0d_latency got %0d want 2", i, dc); end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] er, r, rh; logic [1:0] rm; logic [3:0] f; int dc, dn; logic b1, bd, ba;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin rm = 2'b00; er = 32'h3F800002; end
        1:       begin rm = 2'b01; er = 32'h3F800002; end
        default: begin rm = 2'b10; er = 32'h3F800003; end
      endcase
      run_op(1'b0, 32'h3F800001, 32'h3F800001, rm, 0, r, f, dc, dn, b1, bd, ba, rh);
      $display("round mode=%b: res=%h flags=%b", rm, r, f);
      checks++; if (r !== er)      begin errors++; $display("FAIL round%0d_res got %h want %h", i, r, er); end
      checks++; if (f !== 4'b0001) begin errors++; $display("FAIL round%0d_flags got %b want 0001", i, f); end
    end
  endtask

  task automatic test_range;
    logic [31:0] a, er, r, rh; logic [1:0] rm; logic [3:0] ef, f; int dc, dn; logic b1, bd, ba;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a = 32'h7F000000; rm = 2'b00; er = 32'h7F800000; ef = 4'b0101; end
        1:       begin a = 32'h7F000000; rm = 2'b01; er = 32'h7F7FFFFF; ef = 4'b0101; end
        default: begin a = 32'h00800000; rm = 2'b00; er = 32'h00000000; ef = 4'b0011; end
      endcase
      run_op(1'b0, a, a, rm, 0, r, f, dc, dn, b1, bd, ba, rh);
      $display("range %h^2 mode=%b: res=%h flags=%b", a, rm, r, f);
      checks++; if (r !== er) begin errors++; $display("FAIL range%0d_res got %h want %h", i, r, er); end
      checks++; if (f !== ef) begin errors++; $display("FAIL range%0d_flags got %b want %b", i, f, ef); end
    end
  endtask

  task automatic test_ready_while_busy;
    logic [31:0] r, rh; logic [3:0] f; int dc, dn; logic b1, bd, ba;
    run_op(1'b0, 32'h40000000, 32'h40200000, 2'b00, 5, r, f, dc, dn, b1, bd, ba, rh);
    $display("ready while busy: res=%h done_cycle=%0d dones=%0d", r, dc, dn);
    checks++; if (dn !== 1)           begin errors++; $display("FAIL busy_ignore_count got %0d want 1", dn); end
    checks++; if (dc !== 28)          begin errors++; $display("FAIL busy_ignore_latency got %0d want 28", dc); end
    checks++; if (r !== 32'h40A00000) begin errors++; $display("FAIL busy_ignore_res got %h want 40a00000", r); end
  endtask

  task automatic test_reset_midop;
    int dn, dc;
    dn = 0; dc = 0;
    ready = 1'b1; op1 = 32'h3F800001; op2 = 32'h3F800001; rnd_mode = 2'b10;
    tick();
    ready = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (done) dn++;
      tick();
    end
    rst = 1'b1;
    if (done) dn++;
    tick();
    rst = 1'b0;
    $display("reset mid-op: res=%h flags=%b done=%b busy=%b dones=%0d", res, flags, done, busy, dn);
    checks++; if (dn !== 0)       begin errors++; $display("FAIL midrst_done_before got %0d want 0", dn); end
    checks++; if (res !== 32'h0)  begin errors++; $display("FAIL midrst_res got %h want 00000000", res); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL midrst_flags got %b want 0000", flags); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    ready = 1'b1; op1 = 32'h40000000; op2 = 32'h40000000; rnd_mode = 2'b00;
    tick();
    ready = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin dn++; dc = c; end
      tick();
    end
    $display("after reset 2.0*2.0: res=%h done_cycle=%0d dones=%0d", res, dc, dn);
    checks++; if (dc !== 28)            begin errors++; $display("FAIL postrst_latency got %0d want 28", dc); end
    checks++; if (dn !== 1)             begin errors++; $display("FAIL postrst_done_count got %0d want 1", dn); end
    checks++; if (res !== 32'h40800000) begin errors++; $display("FAIL postrst_res got %h want 40800000", res); end
  endtask

  task automatic test_half;
    logic [31:0] r, rh; logic [3:0] f; int dc, dn; logic b1, bd, ba;
    run_op(1'b1, 32'h4000, 32'h3E00, 2'b00, 0, r, f, dc, dn, b1, bd, ba, rh);
    $display("half 2.0*1.5: res=%h flags=%b done_cycle=%0d", r, f, dc);
    checks++; if (r !== 32'h4200) begin errors++; $display("FAIL half_res got %h want 4200", r); end
    checks++; if (f !== 4'b0000)  begin errors++; $display("FAIL half_flags got %b want 0000", f); end
    checks++; if (dc !== 15)      begin errors++; $display("FAIL half_latency got %0d want 15", dc); end
    run_op(1'b1, 32'h7BFF, 32'h4000, 2'b00, 0, r, f, dc, dn, b1, bd, ba, rh);
    $display("half ovf 7bff*4000: res=%h flags=%b", r, f);
    checks++; if (r !== 32'h7C00) begin errors++; $display("FAIL half_ovf_res got %h want 7c00", r); end
    checks++; if (f !== 4'b0101)  begin errors++; $display("FAIL half_ovf_flags got %b want 0101", f); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_rounding();
    test_range();
    test_ready_while_busy();
    test_reset_midop();
    test_half();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_param.md
Name: fp_mul_param

Overview:
Parametrised, multi-cycle IEEE-754 floating-point multiplier. It is the successor of the fixed single-precision multiplier. It generalises exponent and mantissa widths, adds four run-time rounding modes and exception flags, and has defined special-case handling. It keeps the same ready/done start-pulse handshake, so existing benches and controllers drive it unchanged.

Parameters:
EXP_W, 8, exponent field width (BIAS = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width; significand is MAN_W+1 bits
W (derived, not overridable), 1+EXP_W+MAN_W, operand/result width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
ready  in  1  start strobe; sampled only in IDLE
op1  in  W  operand A, captured on accepted ready
op2  in  W  operand B, captured on accepted ready
rnd_mode  in  2  captured with operands: 00 RNE, 01 RTZ, 10 RUP(+inf), 11 RDN(-inf)
res  out  W  result; held until next accepted start
done  out  1  one-cycle pulse, res/flags valid
busy  out  1  high from cycle after accept through DONE cycle
flags  out  4  {invalid, overflow, underflow, inexact}; held with res

Behaviour:
- Reset: res=0, done=0, busy=0, flags=0, state IDLE. Applies on the next edge from any state; an in-flight operation is discarded with no done pulse.
- Accept: edge where state=IDLE and ready=1 (cycle 0). Operands and rnd_mode are registered; res/flags keep their old values until DONE.
- ready while busy: ignored, no queueing.
- FSM: IDLE -> UNPACK -> MULT -> NORM -> ROUND -> DONE -> IDLE. UNPACK jumps to DONE directly for special operands.
- UNPACK (cycle 1):
  - Classify each operand as zero, subnormal, inf, NaN or normal.
  - Subnormal inputs are flushed to signed zero with no flag.
  - Sign = s1 xor s2.
  - Exponent = e1+e2-BIAS in a signed EXP_W+2 bit register.
- Special results (ready in DONE at cycle 2):
  - Any NaN, or inf*zero: canonical qNaN (sign 0, exp all 1s, fraction MSB 1); invalid=1.
  - inf*finite-nonzero or inf*inf: signed inf, no flags.
  - zero*finite: signed zero, no flags.
- MULT: iterative shift-add, one multiplier bit per cycle, MAN_W+1 cycles (cycles 2..MAN_W+2). Product is 2*MAN_W+2 bits.
- NORM (cycle MAN_W+3): if product MSB is set, shift right 1 and increment exponent. Form guard bit and sticky (OR of all discarded bits).
- ROUND (cycle MAN_W+4):
  - Increment decision per mode: RNE uses guard&(sticky|lsb); RTZ never increments; RUP increments on (guard|sticky)&~sign; RDN increments on (guard|sticky)&sign.
  - Significand carry-out renormalises and increments the exponent.
  - inexact = guard|sticky.
- Overflow (final exponent >= 2^EXP_W-1): overflow=1, inexact=1. Result is inf for RNE, and for RUP when positive / RDN when negative; otherwise ±max finite (exp 2^EXP_W-2, fraction all 1s).
- Underflow (final exponent <= 0): output flushed to signed zero; underflow=1, inexact=1.
- DONE:
  - res and flags are loaded at the edge entering DONE, so they are valid in the DONE cycle.
  - done=1 for exactly one cycle; busy is also high in this cycle.
  - Returns to IDLE; a new start can be accepted the cycle after DONE.
- Latency: done high in cycle MAN_W+5 (28 for default parameters) on the normal path, and in cycle 2 on the special path.

Decomposition:
- Package fp_mul_pkg:
  - rounding-mode constants RM_RNE/RM_RTZ/RM_RUP/RM_RDN
  - FSM state enum
  - flag bit indices FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_INX=0
- Sub-module fp_sig_mul_seq:
  - sequential (MAN_W+1)x(MAN_W+1) shift-add multiplier with start/done
  - parameter N=MAN_W+1
  - the top FSM waits on its done

Test Plan:
- 0x40000000 (2.0) * 0x40200000 (2.5), RNE -> res 0x40A00000, flags 0, done high in cycle 28 only; 0x3FA00000 (1.25)/0x3F800000 (1.0) presented on the following cycle (ready=0) must not alter the operation.
- 0x42C86666 * 0x80000000 -> 0x80000000 with done in cycle 2; 0xFF800000 * 0x45185B75 -> 0xFF800000; 0x7F800000 * 0x00000000 -> 0x7FC00000, flags 4'b1000.
- 0x3F800001 * 0x3F800001: RNE -> 0x3F800002, RTZ -> 0x3F800002, RUP -> 0x3F800003, flags 4'b0001 in each case.
- 0x7F000000 * 0x7F000000: RNE -> 0x7F800000, RTZ -> 0x7F7FFFFF, flags 4'b0101; 0x00800000 * 0x00800000 RNE -> 0x00000000, flags 4'b0011.
- ready pulsed at cycle 5 of a busy operation -> ignored, exactly one done; rst at cycle 10 -> no done, outputs 0, next accept on the first cycle after rst deasserts.
- EXP_W=5, MAN_W=10 instance: 0x4000 * 0x3E00 (2.0*1.5) -> 0x4200, done in cycle 15; 0x7BFF * 0x4000 RNE -> 0x7C00, overflow+inexact.
